// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte producers.
// Captures the winner's byte, holds tx_start/tx_din for START_HOLD cycles, waits for
// tx_done_tick (or a watchdog abort), reports completion, then returns to idle.
module uart_tx_arbiter #(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned N_BIT      = 8,
   parameter int unsigned START_HOLD = 3,
   parameter int unsigned TIMEOUT    = 262143
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [N_REQ-1:0]                             req,
   input  logic [N_REQ*N_BIT-1:0]                       req_data,
   output logic [N_REQ-1:0]                             grant,
   output logic                                         busy,
   output logic                                         tx_start,
   output logic [N_BIT-1:0]                             tx_din,
   input  logic                                         tx_done_tick,
   output logic                                         sent_valid,
   output logic [(N_REQ > 1 ? $clog2(N_REQ) : 1)-1:0]   sent_id,
   output logic                                         err_timeout
);

   localparam int unsigned IdW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   // One extra bit so (last_id + offset) never overflows before the modulo wrap.
   localparam int unsigned IdxW  = IdW + 1;
   localparam int unsigned HoldW = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
   localparam int unsigned WdW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [HoldW-1:0] HoldLast = HoldW'(START_HOLD - 1);
   localparam logic [WdW-1:0]   WdLast   = WdW'(TIMEOUT - 1);
   localparam logic [IdxW-1:0]  NReqIdx  = IdxW'(N_REQ);
   localparam logic [IdW-1:0]   LastInit = IdW'(N_REQ - 1);

   typedef enum logic [1:0] {StIdle, StLaunch, StWait, StDone} state_e;

   state_e             state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic               busy_q, busy_d;
   logic               tx_start_q, tx_start_d;
   logic [N_BIT-1:0]   tx_din_q, tx_din_d;
   logic               sent_valid_q, sent_valid_d;
   logic [IdW-1:0]     sent_id_q, sent_id_d;
   logic               err_q, err_d;
   logic [IdW-1:0]     last_id_q, last_id_d;
   logic [IdW-1:0]     cur_id_q, cur_id_d;
   logic [HoldW-1:0]   hold_q, hold_d;
   logic [WdW-1:0]     wdog_q, wdog_d;

   logic               win_valid;
   logic [IdW-1:0]     win_id;
   logic [IdxW-1:0]    scan_idx;
   logic [N_BIT-1:0]   win_data;

   // Rotating-priority search: first set req bit upward from last_id+1, wrapping.
   always_comb begin
      win_valid = 1'b0;
      win_id    = '0;
      scan_idx  = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         scan_idx = IdxW'(last_id_q) + IdxW'(i);
         if (scan_idx >= NReqIdx) begin
            scan_idx = scan_idx - NReqIdx;
         end
         if (!win_valid && req[scan_idx[IdW-1:0]]) begin
            win_valid = 1'b1;
            win_id    = scan_idx[IdW-1:0];
         end
      end
      win_data = req_data[32'(win_id) * N_BIT +: N_BIT];
   end

   // Next-state and registered-output logic; pulses default low, everything else holds.
   always_comb begin
      state_d      = state_q;
      grant_d      = '0;
      tx_start_d   = tx_start_q;
      tx_din_d     = tx_din_q;
      sent_valid_d = 1'b0;
      err_d        = 1'b0;
      sent_id_d    = sent_id_q;
      last_id_d    = last_id_q;
      cur_id_d     = cur_id_q;
      hold_d       = hold_q;
      wdog_d       = wdog_q;

      unique case (state_q)
         StIdle: begin
            if (win_valid) begin
               grant_d[win_id] = 1'b1;
               tx_din_d        = win_data;
               cur_id_d        = win_id;
               last_id_d       = win_id;
               tx_start_d      = 1'b1;
               hold_d          = '0;
               state_d         = StLaunch;
            end
         end
         StLaunch: begin
            if (hold_q == HoldLast) begin
               tx_start_d = 1'b0;
               wdog_d     = '0;
               state_d    = StWait;
            end else begin
               hold_d = hold_q + HoldW'(1);
            end
         end
         StWait: begin
            // A done tick on the final watchdog cycle still counts as success.
            if (tx_done_tick) begin
               sent_valid_d = 1'b1;
               sent_id_d    = cur_id_q;
               state_d      = StDone;
            end else if (wdog_q == WdLast) begin
               err_d     = 1'b1;
               sent_id_d = cur_id_q;
               state_d   = StDone;
            end else begin
               wdog_d = wdog_q + WdW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   // State and output registers with immediate reset; index 0 gets first priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         busy_q       <= 1'b0;
         tx_start_q   <= 1'b0;
         tx_din_q     <= '0;
         sent_valid_q <= 1'b0;
         sent_id_q    <= '0;
         err_q        <= 1'b0;
         last_id_q    <= LastInit;
         cur_id_q     <= '0;
         hold_q       <= '0;
         wdog_q       <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         busy_q       <= busy_d;
         tx_start_q   <= tx_start_d;
         tx_din_q     <= tx_din_d;
         sent_valid_q <= sent_valid_d;
         sent_id_q    <= sent_id_d;
         err_q        <= err_d;
         last_id_q    <= last_id_d;
         cur_id_q     <= cur_id_d;
         hold_q       <= hold_d;
         wdog_q       <= wdog_d;
      end
   end

   assign grant       = grant_q;
   assign busy        = busy_q;
   assign tx_start    = tx_start_q;
   assign tx_din      = tx_din_q;
   assign sent_valid  = sent_valid_q;
   assign sent_id     = sent_id_q;
   assign err_timeout = err_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter (8N1 + even parity, 16x S_tick) among N_REQ byte producers.
- Selects one requester, captures its byte and drives the transmitter's tx_start/din handshake.
- Waits for the transmitter's tx_done_tick, reports completion, then moves on.
- A watchdog recovers the arbiter if the transmitter never signals done.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- N_BIT, 8, data bits per character; must match the transmitter
- START_HOLD, 3, cycles tx_start is held high with din stable (>=2; the transmitter needs 2 cycles in IDLE to load and qualify its frame)
- TIMEOUT, 262143, max cycles in WAIT before abort (>= 11 bits x 16 ticks x tick period)

Ports:
- clk, in, 1, system clock
- rst, in, 1, asynchronous active-high reset
- req, in, N_REQ, per-requester request level
- req_data, in, N_REQ*N_BIT, requester k's byte at [k*N_BIT +: N_BIT]
- grant, out, N_REQ, one-hot one-cycle pulse: requester's byte accepted
- busy, out, 1, high whenever state != IDLE
- tx_start, out, 1, to transmitter tx_start
- tx_din, out, N_BIT, to transmitter din
- tx_done_tick, in, 1, from transmitter
- sent_valid, out, 1, one-cycle pulse: character finished
- sent_id, out, clog2(N_REQ), index of the finished requester; valid with sent_valid and with err_timeout
- err_timeout, out, 1, one-cycle pulse: watchdog abort

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - grant, tx_start, tx_din, sent_valid, sent_id, err_timeout, busy = 0.
  - last_id = N_REQ-1, so index 0 has first priority.
- All outputs are registered.
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - If req != 0, pick the winner k as the first set bit searching upward, circularly, from (last_id+1) mod N_REQ.
  - At that edge:
    - grant[k] <= 1 for one cycle.
    - tx_din <= byte k.
    - cur_id <= k and last_id <= k.
    - tx_start <= 1, hold counter <= 0.
    - state <= LAUNCH.
  - Latency: req sampled high at edge E, so grant and tx_start are high in the cycle after E.
- LAUNCH:
  - tx_start stays 1 and tx_din stays frozen for exactly START_HOLD cycles.
  - Counter reaches START_HOLD-1: tx_start <= 0, watchdog <= 0, state <= WAIT.
  - tx_din holds its value until the next grant.
- WAIT:
  - tx_done_tick = 1: sent_valid <= 1, sent_id <= cur_id, state <= DONE.
  - Otherwise, watchdog reaches TIMEOUT-1: err_timeout <= 1, sent_id <= cur_id, state <= DONE.
  - If tx_done_tick and the timeout fall on the same cycle, done wins; no error is raised.
- DONE: pulses clear, state <= IDLE. This enforces at least 2 cycles with tx_start = 0 between characters, so the transmitter cannot retrigger on a stale start.
- tx_done_tick outside WAIT is ignored.
- Requester handshake:
  - A requester holds req and req_data stable until it sees its grant bit.
  - req sampled only in IDLE; requests arriving in other states wait.
  - req dropped before grant means the request is withdrawn; it is never granted.
  - Holding req after grant requests another character; it is re-arbitrated with the new last_id, so other requesters get fairness.
- Fairness: with all N_REQ requests continuously high, grants rotate 0,1,..,N_REQ-1,0; no requester waits more than N_REQ-1 characters.
- Simultaneous events: multiple req bits in the same cycle are resolved solely by the rotating priority.
- Width: sent_id is clog2(N_REQ) bits, minimum 1. The rotating search index wraps modulo N_REQ.
- Reset mid-operation: all outputs return to reset values immediately; the in-flight character is abandoned without sent_valid; the transmitter is reset by the same rst.

Test Plan:
- Single request: req=4'b0100, byte2=8'hA5 -> grant=4'b0100 one cycle after sampling; tx_start high exactly 3 cycles with tx_din=8'hA5; after tx_done_tick, sent_valid pulse with sent_id=2; serial line carries 0,A5 LSB-first, parity 0, 1.
- Round robin: req=4'b1111 held, bytes 8'h10/11/12/13 -> grant order 0,1,2,3,0; sent_id follows; exactly one grant per character.
- Arbitration skip: last_id=1, req=4'b1001 -> grant index 3 first, then index 0.
- Withdrawal: req[1] pulsed 1 cycle while in WAIT -> never granted, no extra tx_start.
- Timeout: tx_done_tick tied 0, TIMEOUT=100 -> err_timeout pulses 100 cycles after WAIT entry with sent_id=cur_id; no sent_valid; returns to IDLE and next req is granted.
- Reset in LAUNCH: rst asserted at 2nd tx_start cycle -> tx_start=0, busy=0, grant=0 immediately; after release req=4'b0001 is granted to index 0.
